// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receive FSM state encoding and the
//                baud divisor computation used by receiver and transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_e;

  // Clocks per oversampling tick, rounded to nearest:
  // round(clk_freq / (baud * ovs)), never below 1.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    longint den;
    longint q;
    den = longint'(baud) * longint'(ovs);
    q   = (longint'(clk_freq) + den / 2) / den;
    if (q < 1) begin
      q = 1;
    end
    return int'(q);
  endfunction

endpackage
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_tick_gen
//  Description : Free-running divider producing a one-cycle tick every DIV
//                clocks (oversampling tick for the UART receiver/transmitter).
//  Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == c_last);
  assign tick   = w_wrap;

  // Count 0..DIV-1 and wrap; never gated so tick phase is continuous
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1-style UART receiver, 16x oversampled. Synchronizes the
//                rx pin, tracks frames with a small FSM and presents each
//                good byte with a one-cycle strobe; bad stop bits raise a
//                one-cycle frame error and wait for the line to go idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 19_200,
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done_tick,
  output logic                 frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
  localparam int SW  = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int NW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] c_s_half = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] c_s_last = SW'(OVS - 1);
  localparam logic [NW-1:0] c_n_last = NW'(DATA_BITS - 1);

  // Synchronizer and tick
  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic                 w_tick;

  // FSM state and datapath registers
  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [SW-1:0]        r_s;
  logic [SW-1:0]        w_s_nxt;
  logic [NW-1:0]        r_n;
  logic [NW-1:0]        w_n_nxt;
  logic [DATA_BITS-1:0] r_b;
  logic [DATA_BITS-1:0] w_b_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;

  assign w_rx_s       = r_sync[1];
  assign rx_data      = r_data;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr;

  baud_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  // Two-flop synchronizer for the asynchronous pin; resets to idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  // FSM and datapath registers; outputs are registered here as well
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_n     <= w_n_nxt;
      r_b     <= w_b_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // Next-state and datapath decisions; strobes default low every cycle
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_n_nxt     = r_n;
    w_b_nxt     = r_b;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = ST_START;
          w_s_nxt     = '0;
        end
      end

      ST_START: begin
        if (w_tick) begin
          if (r_s == c_s_half) begin
            // Mid start bit: still low means a real frame, high was a glitch
            if (!w_rx_s) begin
              w_state_nxt = ST_DATA;
              w_s_nxt     = '0;
              w_n_nxt     = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          if (r_s == c_s_last) begin
            w_b_nxt = {w_rx_s, r_b[DATA_BITS-1:1]};
            w_s_nxt = '0;
            if (r_n == c_n_last) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_n_nxt = r_n + NW'(1);
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          if (r_s == c_s_last) begin
            if (w_rx_s) begin
              w_data_nxt  = r_b;
              w_done_nxt  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              // Stop bit low: report once, then wait out the break
              w_ferr_nxt  = 1'b1;
              w_state_nxt = ST_WAIT_HIGH;
            end
          end else begin
            w_s_nxt = r_s + SW'(1);
          end
        end
      end

      ST_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
